// File: rtl/zap_wb_splitter.sv
// Wishbone 1-to-2 address splitter with burst locking, ack timeout and
// unmapped-access error reporting.
module zap_wb_splitter #(
    parameter logic [31:0] S0_BASE = 32'h0000_0000,
    parameter logic [31:0] S0_MASK = 32'hF000_0000,
    parameter logic [31:0] S1_BASE = 32'h1000_0000,
    parameter logic [31:0] S1_MASK = 32'hF000_0000,
    parameter int          TIMEOUT = 16
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_wb_cyc,
    input  logic        i_wb_stb,
    input  logic        i_wb_wen,
    input  logic [3:0]  i_wb_sel,
    input  logic [31:0] i_wb_adr,
    input  logic [31:0] i_wb_dat,
    input  logic [2:0]  i_wb_cti,
    output logic        o_wb_ack,
    output logic        o_wb_err,
    output logic [31:0] o_wb_dat,
    output logic        o_s0_wb_cyc,
    output logic        o_s0_wb_stb,
    output logic        o_s0_wb_wen,
    output logic [3:0]  o_s0_wb_sel,
    output logic [31:0] o_s0_wb_adr,
    output logic [31:0] o_s0_wb_dat,
    output logic [2:0]  o_s0_wb_cti,
    input  logic        i_s0_wb_ack,
    input  logic [31:0] i_s0_wb_dat,
    output logic        o_s1_wb_cyc,
    output logic        o_s1_wb_stb,
    output logic        o_s1_wb_wen,
    output logic [3:0]  o_s1_wb_sel,
    output logic [31:0] o_s1_wb_adr,
    output logic [31:0] o_s1_wb_dat,
    output logic [2:0]  o_s1_wb_cti,
    input  logic        i_s1_wb_ack,
    input  logic [31:0] i_s1_wb_dat
);
    // state | meaning
    // IDLE  | no slave selected, decode on cyc & stb
    // SLV0  | locked to slave 0 until final ack or cyc drop
    // SLV1  | locked to slave 1 until final ack or cyc drop
    // ERR   | unmapped or timed-out access, wait for cyc drop
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SLV0 = 2'd1;
    localparam logic [1:0] SLV1 = 2'd2;
    localparam logic [1:0] ERR  = 2'd3;

    localparam logic [2:0]  CTI_CLASSIC = 3'b000;
    localparam logic [2:0]  CTI_EOB     = 3'b111;
    localparam logic [15:0] CNT_LAST    = 16'(TIMEOUT - 1);

    logic [1:0]  r_state, w_state_nxt;
    logic [15:0] r_cnt, w_cnt_nxt;
    logic        r_err_first, w_err_first_nxt;
    logic        w_hit0, w_hit1, w_sel0, w_sel1;
    logic        w_slv_ack, w_last_cti, w_timeout;

    assign w_hit0     = (i_wb_adr & S0_MASK) == S0_BASE;
    assign w_hit1     = (i_wb_adr & S1_MASK) == S1_BASE;
    assign w_sel0     = r_state == SLV0;
    assign w_sel1     = r_state == SLV1;
    assign w_slv_ack  = (w_sel0 & i_s0_wb_ack) | (w_sel1 & i_s1_wb_ack);
    assign w_last_cti = (i_wb_cti == CTI_CLASSIC) || (i_wb_cti == CTI_EOB);
    // A same-cycle ack always beats the timeout.
    assign w_timeout  = i_wb_stb & ~w_slv_ack & (r_cnt == CNT_LAST);

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_err_first_nxt = 1'b0;
        case (r_state)
            IDLE: begin
                w_cnt_nxt = '0;
                if (i_wb_cyc & i_wb_stb) begin
                    if (w_hit0) begin
                        w_state_nxt = SLV0;
                    end else if (w_hit1) begin
                        w_state_nxt = SLV1;
                    end else begin
                        w_state_nxt     = ERR;
                        w_err_first_nxt = 1'b1;
                    end
                end
            end
            SLV0, SLV1: begin
                if (!i_wb_cyc) begin
                    w_state_nxt = IDLE;
                end else if (w_slv_ack) begin
                    w_cnt_nxt = '0;
                    if (w_last_cti) w_state_nxt = IDLE;
                end else if (w_timeout) begin
                    w_state_nxt     = ERR;
                    w_err_first_nxt = 1'b1;
                end else if (i_wb_stb) begin
                    w_cnt_nxt = r_cnt + 16'd1;
                end
            end
            default: begin
                if (!i_wb_cyc) w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_err_first <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_err_first <= w_err_first_nxt;
        end
    end

    assign o_s0_wb_cyc = w_sel0 & i_wb_cyc;
    assign o_s0_wb_stb = w_sel0 & i_wb_stb;
    assign o_s0_wb_wen = w_sel0 & i_wb_wen;
    assign o_s0_wb_sel = {4{w_sel0}} & i_wb_sel;
    assign o_s0_wb_adr = {32{w_sel0}} & i_wb_adr;
    assign o_s0_wb_dat = {32{w_sel0}} & i_wb_dat;
    assign o_s0_wb_cti = {3{w_sel0}} & i_wb_cti;

    assign o_s1_wb_cyc = w_sel1 & i_wb_cyc;
    assign o_s1_wb_stb = w_sel1 & i_wb_stb;
    assign o_s1_wb_wen = w_sel1 & i_wb_wen;
    assign o_s1_wb_sel = {4{w_sel1}} & i_wb_sel;
    assign o_s1_wb_adr = {32{w_sel1}} & i_wb_adr;
    assign o_s1_wb_dat = {32{w_sel1}} & i_wb_dat;
    assign o_s1_wb_cti = {3{w_sel1}} & i_wb_cti;

    assign o_wb_ack = w_slv_ack;
    assign o_wb_err = (r_state == ERR) & r_err_first;
    assign o_wb_dat = w_sel0 ? i_s0_wb_dat : (w_sel1 ? i_s1_wb_dat : 32'd0);
endmodule

// File: tb/tb_zap_wb_splitter.sv
// Randomized + directed bench for zap_wb_splitter: a default-map instance and an
// overlapping-window instance with a short timeout, both checked against a transaction model.
module tb_zap_wb_splitter;
    logic        i_clk, i_reset;
    logic        i_wb_cyc, i_wb_stb, i_wb_wen;
    logic [3:0]  i_wb_sel;
    logic [31:0] i_wb_adr, i_wb_dat;
    logic [2:0]  i_wb_cti;
    logic        i_s0_wb_ack, i_s1_wb_ack;
    logic [31:0] i_s0_wb_dat, i_s1_wb_dat;

    logic        d_ack [2], d_err [2];
    logic [31:0] d_dat [2];
    logic        d_s0_cyc [2], d_s0_stb [2], d_s0_wen [2];
    logic [3:0]  d_s0_sel [2];
    logic [31:0] d_s0_adr [2], d_s0_dat [2];
    logic [2:0]  d_s0_cti [2];
    logic        d_s1_cyc [2], d_s1_stb [2], d_s1_wen [2];
    logic [3:0]  d_s1_sel [2];
    logic [31:0] d_s1_adr [2], d_s1_dat [2];
    logic [2:0]  d_s1_cti [2];

    int n_vec = 0;
    int n_err = 0;

    // Model state per instance: -1 idle, 0/1 slave owning the cycle, 2 error.
    int          m_tgt [2];
    int          m_wait [2];
    bit          m_errp [2];
    logic [31:0] p_b0 [2], p_m0 [2], p_b1 [2], p_m1 [2];
    int          p_to [2];

    zap_wb_splitter u_dut (
        .i_clk(i_clk), .i_reset(i_reset),
        .i_wb_cyc(i_wb_cyc), .i_wb_stb(i_wb_stb), .i_wb_wen(i_wb_wen),
        .i_wb_sel(i_wb_sel), .i_wb_adr(i_wb_adr), .i_wb_dat(i_wb_dat), .i_wb_cti(i_wb_cti),
        .o_wb_ack(d_ack[0]), .o_wb_err(d_err[0]), .o_wb_dat(d_dat[0]),
        .o_s0_wb_cyc(d_s0_cyc[0]), .o_s0_wb_stb(d_s0_stb[0]), .o_s0_wb_wen(d_s0_wen[0]),
        .o_s0_wb_sel(d_s0_sel[0]), .o_s0_wb_adr(d_s0_adr[0]), .o_s0_wb_dat(d_s0_dat[0]),
        .o_s0_wb_cti(d_s0_cti[0]), .i_s0_wb_ack(i_s0_wb_ack), .i_s0_wb_dat(i_s0_wb_dat),
        .o_s1_wb_cyc(d_s1_cyc[0]), .o_s1_wb_stb(d_s1_stb[0]), .o_s1_wb_wen(d_s1_wen[0]),
        .o_s1_wb_sel(d_s1_sel[0]), .o_s1_wb_adr(d_s1_adr[0]), .o_s1_wb_dat(d_s1_dat[0]),
        .o_s1_wb_cti(d_s1_cti[0]), .i_s1_wb_ack(i_s1_wb_ack), .i_s1_wb_dat(i_s1_wb_dat)
    );

    zap_wb_splitter #(
        .S0_BASE(32'h0000_0000), .S0_MASK(32'hF000_0000),
        .S1_BASE(32'h0000_0000), .S1_MASK(32'hF000_0000), .TIMEOUT(5)
    ) u_ovl (
        .i_clk(i_clk), .i_reset(i_reset),
        .i_wb_cyc(i_wb_cyc), .i_wb_stb(i_wb_stb), .i_wb_wen(i_wb_wen),
        .i_wb_sel(i_wb_sel), .i_wb_adr(i_wb_adr), .i_wb_dat(i_wb_dat), .i_wb_cti(i_wb_cti),
        .o_wb_ack(d_ack[1]), .o_wb_err(d_err[1]), .o_wb_dat(d_dat[1]),
        .o_s0_wb_cyc(d_s0_cyc[1]), .o_s0_wb_stb(d_s0_stb[1]), .o_s0_wb_wen(d_s0_wen[1]),
        .o_s0_wb_sel(d_s0_sel[1]), .o_s0_wb_adr(d_s0_adr[1]), .o_s0_wb_dat(d_s0_dat[1]),
        .o_s0_wb_cti(d_s0_cti[1]), .i_s0_wb_ack(i_s0_wb_ack), .i_s0_wb_dat(i_s0_wb_dat),
        .o_s1_wb_cyc(d_s1_cyc[1]), .o_s1_wb_stb(d_s1_stb[1]), .o_s1_wb_wen(d_s1_wen[1]),
        .o_s1_wb_sel(d_s1_sel[1]), .o_s1_wb_adr(d_s1_adr[1]), .o_s1_wb_dat(d_s1_dat[1]),
        .o_s1_wb_cti(d_s1_cti[1]), .i_s1_wb_ack(i_s1_wb_ack), .i_s1_wb_dat(i_s1_wb_dat)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    task automatic compare_inst(input int k);
        logic [73:0] bus, exp_s0, exp_s1;
        logic        exp_ack, exp_err;
        logic [31:0] exp_dat;
        bus     = {i_wb_cyc, i_wb_stb, i_wb_wen, i_wb_sel, i_wb_adr, i_wb_dat, i_wb_cti};
        exp_s0  = '0;
        exp_s1  = '0;
        exp_ack = 1'b0;
        exp_err = 1'b0;
        exp_dat = '0;
        case (m_tgt[k])
            0: begin exp_s0 = bus; exp_ack = i_s0_wb_ack; exp_dat = i_s0_wb_dat; end
            1: begin exp_s1 = bus; exp_ack = i_s1_wb_ack; exp_dat = i_s1_wb_dat; end
            2: exp_err = m_errp[k];
            default: ;
        endcase
        check_eq($sformatf("u%0d.s0_bus", k), 128'({d_s0_cyc[k], d_s0_stb[k], d_s0_wen[k],
                 d_s0_sel[k], d_s0_adr[k], d_s0_dat[k], d_s0_cti[k]}), 128'(exp_s0));
        check_eq($sformatf("u%0d.s1_bus", k), 128'({d_s1_cyc[k], d_s1_stb[k], d_s1_wen[k],
                 d_s1_sel[k], d_s1_adr[k], d_s1_dat[k], d_s1_cti[k]}), 128'(exp_s1));
        check_eq($sformatf("u%0d.ack", k), 128'(d_ack[k]), 128'(exp_ack));
        check_eq($sformatf("u%0d.err", k), 128'(d_err[k]), 128'(exp_err));
        check_eq($sformatf("u%0d.dat", k), 128'(d_dat[k]), 128'(exp_dat));
        check_eq($sformatf("u%0d.ack_err_excl", k), 128'(d_ack[k] & d_err[k]), 128'(0));
    endtask

    task automatic model_edge(input int k);
        bit ack;
        if (i_reset) begin
            m_tgt[k]  = -1;
            m_wait[k] = 0;
            m_errp[k] = 0;
            return;
        end
        m_errp[k] = 0;
        case (m_tgt[k])
            -1: if (i_wb_cyc && i_wb_stb) begin
                m_wait[k] = 0;
                if ((i_wb_adr & p_m0[k]) == p_b0[k])      m_tgt[k] = 0;
                else if ((i_wb_adr & p_m1[k]) == p_b1[k]) m_tgt[k] = 1;
                else begin m_tgt[k] = 2; m_errp[k] = 1; end
            end
            0, 1: begin
                ack = (m_tgt[k] == 0) ? i_s0_wb_ack : i_s1_wb_ack;
                if (!i_wb_cyc) m_tgt[k] = -1;
                else if (ack) begin
                    m_wait[k] = 0;
                    if (i_wb_cti == 3'b000 || i_wb_cti == 3'b111) m_tgt[k] = -1;
                end else if (i_wb_stb) begin
                    m_wait[k]++;
                    if (m_wait[k] == p_to[k]) begin m_tgt[k] = 2; m_errp[k] = 1; end
                end
            end
            default: if (!i_wb_cyc) m_tgt[k] = -1;
        endcase
    endtask

    task automatic tick();
        #3;
        compare_inst(0);
        compare_inst(1);
        @(posedge i_clk);
        model_edge(0);
        model_edge(1);
        #1;
    endtask

    task automatic drive(input bit cyc, input bit stb, input logic [31:0] adr,
                         input logic [2:0] cti, input bit a0, input bit a1);
        i_wb_cyc    = cyc;
        i_wb_stb    = stb;
        i_wb_adr    = adr;
        i_wb_cti    = cti;
        i_s0_wb_ack = a0;
        i_s1_wb_ack = a1;
        i_wb_dat    = $urandom;
        i_wb_sel    = 4'($urandom);
        i_wb_wen    = 1'($urandom);
        i_s0_wb_dat = $urandom;
        i_s1_wb_dat = $urandom;
    endtask

    initial begin
        int quiet;
        p_b0 = '{32'h0000_0000, 32'h0000_0000};
        p_m0 = '{32'hF000_0000, 32'hF000_0000};
        p_b1 = '{32'h1000_0000, 32'h0000_0000};
        p_m1 = '{32'hF000_0000, 32'hF000_0000};
        p_to = '{16, 5};
        i_reset = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 3'b000, 1'b0, 1'b0);
        repeat (2) @(posedge i_clk);
        model_edge(0);
        model_edge(1);
        #1;
        i_reset = 1'b0;
        tick();

        // Classic read to slave 0, acked on the third slave cycle.
        drive(1'b1, 1'b1, 32'h0000_0040, 3'b000, 1'b0, 1'b0);
        repeat (3) tick();
        drive(1'b1, 1'b1, 32'h0000_0040, 3'b000, 1'b1, 1'b0);
        i_s0_wb_dat = 32'hCAFE_F00D;
        tick();
        drive(1'b0, 1'b0, 32'h0, 3'b000, 1'b0, 1'b0);
        tick();

        // Four-beat burst to slave 1, acked every cycle.
        drive(1'b1, 1'b1, 32'h1000_0000, 3'b010, 1'b0, 1'b0);
        tick();
        for (int b = 0; b < 4; b++) begin
            drive(1'b1, 1'b1, 32'h1000_0000 + 32'(b * 4), (b == 3) ? 3'b111 : 3'b010, 1'b0, 1'b1);
            tick();
        end
        drive(1'b0, 1'b0, 32'h0, 3'b000, 1'b0, 1'b0);
        tick();

        // Unmapped access, held for a while before cyc drops.
        drive(1'b1, 1'b1, 32'h2000_0000, 3'b000, 1'b0, 1'b0);
        repeat (4) tick();
        drive(1'b0, 1'b0, 32'h0, 3'b000, 1'b0, 1'b0);
        repeat (2) tick();

        // Slave 0 never acks: timeout.
        drive(1'b1, 1'b1, 32'h0000_0100, 3'b000, 1'b0, 1'b0);
        repeat (20) tick();
        drive(1'b0, 1'b0, 32'h0, 3'b000, 1'b0, 1'b0);
        tick();

        // Ack lands on the last permitted wait cycle.
        drive(1'b1, 1'b1, 32'h0000_0200, 3'b000, 1'b0, 1'b0);
        repeat (16) tick();
        drive(1'b1, 1'b1, 32'h0000_0200, 3'b000, 1'b1, 1'b0);
        tick();
        drive(1'b0, 1'b0, 32'h0, 3'b000, 1'b0, 1'b0);
        tick();

        // Reset in the middle of a slave-1 burst, then a stray ack.
        drive(1'b1, 1'b1, 32'h1000_0040, 3'b010, 1'b0, 1'b0);
        tick();
        drive(1'b1, 1'b1, 32'h1000_0044, 3'b010, 1'b0, 1'b1);
        repeat (2) tick();
        i_reset = 1'b1;
        tick();
        i_reset = 1'b0;
        drive(1'b0, 1'b0, 32'h1000_0048, 3'b010, 1'b0, 1'b1);
        repeat (2) tick();

        quiet = 0;
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] adr;
            logic [2:0]  cti;
            case ($urandom_range(0, 3))
                0:       adr = {4'h0, 28'($urandom)};
                1:       adr = {4'h1, 28'($urandom)};
                2:       adr = {4'h2, 28'($urandom)};
                default: adr = $urandom;
            endcase
            case ($urandom_range(0, 2))
                0:       cti = 3'b000;
                1:       cti = 3'b010;
                default: cti = 3'b111;
            endcase
            if (quiet == 0 && $urandom_range(0, 39) == 0) quiet = 20;
            drive($urandom_range(0, 9) != 0, $urandom_range(0, 6) != 0, adr, cti,
                  (quiet == 0) && ($urandom_range(0, 2) == 0),
                  (quiet == 0) && ($urandom_range(0, 2) == 0));
            if (quiet > 0) quiet--;
            i_reset = ($urandom_range(0, 199) == 0);
            tick();
        end
        i_reset = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/zap_wb_splitter.md
ZAP_WB_SPLITTER -- requirements
Module: zap_wb_splitter

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- S0_BASE, 32'h0000_0000, slave-0 address base.
- S0_MASK, 32'hF000_0000, slave-0 compare mask.
- S1_BASE, 32'h1000_0000, slave-1 address base.
- S1_MASK, 32'hF000_0000, slave-1 compare mask.
- TIMEOUT, 16, maximum wait cycles for an ack (2..65535).

REQ-002 Ports, one per line: name, direction, width, meaning.
- i_clk  in  1  clock.
- i_reset  in  1  synchronous, active-high reset.
- i_wb_cyc, i_wb_stb, i_wb_wen  in  1  initiator cycle, strobe and write enable.
- i_wb_sel  in  4  byte selects.
- i_wb_adr, i_wb_dat  in  32  address and write data.
- i_wb_cti  in  3  cycle type.
- o_wb_ack, o_wb_err  out  1  acknowledge and error to the initiator.
- o_wb_dat  out  32  read data to the initiator.
- o_sN_wb_cyc, o_sN_wb_stb, o_sN_wb_wen  out  1  per slave (N = 0, 1).
- o_sN_wb_sel  out  4  per slave.
- o_sN_wb_adr, o_sN_wb_dat  out  32  per slave.
- o_sN_wb_cti  out  3  per slave.
- i_sN_wb_ack  in  1  per slave.
- i_sN_wb_dat  in  32  per slave.

REQ-003 Reset: i_reset synchronous, active-high; clock i_clk; all state updates on posedge i_clk.

Function
REQ-010 FSM states: IDLE, SLV0, SLV1, ERR.
REQ-011 Decode rule, evaluated in IDLE only:
- Sampled when i_wb_cyc & i_wb_stb.
- (i_wb_adr & S0_MASK) == S0_BASE -> SLV0; slave 0 has priority when both windows match.
- Otherwise (i_wb_adr & S1_MASK) == S1_BASE -> SLV1.
- Otherwise -> ERR.
REQ-012 In IDLE, all o_sN_wb_cyc/stb = 0, o_wb_ack = 0, o_wb_err = 0; the decode transition takes exactly one cycle.
REQ-013 In SLVn, the block passes the initiator's cyc, stb, wen, sel, adr, dat and cti combinationally to slave n, with no added latency.
- The other slave's cyc/stb = 0.
- Non-selected slave data, address, sel, wen and cti outputs = 0.
REQ-014 In SLVn, o_wb_ack = i_sn_wb_ack and o_wb_dat = i_sn_wb_dat; acks from the non-selected slave are ignored.
REQ-015 SLVn -> IDLE on either:
- i_sn_wb_ack with i_wb_cti equal to CTI_CLASSIC (3'b000) or CTI_EOB (3'b111);
- i_wb_cyc == 0.
REQ-016 Bursts (CTI_BURST, 3'b010) stay locked to the selected slave until REQ-015 holds; addresses within a burst are not re-decoded.
REQ-017 Timeout counter (16-bit) in SLVn:
- Cleared on state entry and on every i_sn_wb_ack.
- Increments each cycle stb is high with no ack.
REQ-018 When the counter reaches TIMEOUT-1 without an ack:
- Next cycle: state = ERR; slave n cyc/stb forced to 0 from that cycle.
REQ-019 ERR behaviour:
- o_wb_err = 1 for exactly the first ERR cycle, 0 thereafter.
- o_wb_ack = 0; o_wb_dat = 0.
- No slave selected.
- Stay in ERR until i_wb_cyc == 0, then go to IDLE.
REQ-020 Unmapped access sampled in IDLE at cycle N -> o_wb_err = 1 at N+1.
REQ-021 o_wb_ack and o_wb_err are never both 1 in the same cycle.
REQ-022 o_wb_dat = 0 in IDLE and ERR.
REQ-023 An ack arriving in the same cycle the counter reaches TIMEOUT-1 wins: ack forwarded, no error.

Reset
REQ-030 Reset behaviour:
- State = IDLE, counter = 0, error flag = 0.
- All o_sN_* outputs = 0; o_wb_ack = 0, o_wb_err = 0, o_wb_dat = 0.
REQ-031 Reset asserted mid-transfer:
- Drops slave cyc/stb the cycle after reset is sampled.
- No ack or err is generated for the aborted transfer.

Verification
REQ-040 Classic read, adr 0x0000_0040 -> o_s0_wb_stb = 1 from cycle 1; slave-0 ack with dat 0xCAFE_F00D at cycle 3 -> o_wb_ack = 1 and o_wb_dat = 0xCAFE_F00D at cycle 3; IDLE at cycle 4.
REQ-041 4-beat burst at 0x1000_0000 (CTI 010,010,010,111), slave 1 acks every cycle -> four o_wb_acks; o_s0_wb_cyc stays 0 throughout; IDLE after the EOB ack.
REQ-042 Access to 0x2000_0000 -> o_wb_err = 1 one cycle later for one cycle; no slave strobed; state holds ERR until cyc drops, then IDLE.
REQ-043 Access to slave 0 with no ack, TIMEOUT = 16 -> o_s0_wb_stb drops and o_wb_err pulses 16 cycles after SLV0 entry; ack arriving exactly at TIMEOUT-1 -> ack forwarded, no err.
REQ-044 i_reset asserted during a slave-1 burst -> all slave outputs 0 the next cycle; a spurious i_s1_wb_ack afterwards is not forwarded.
REQ-045 Both windows overlap (S1_BASE = S0_BASE) -> slave 0 is selected.
